// File: rtl/led_blink_ctrl.sv
// Multi-channel LED pattern generator: OFF / ON / free-running BLINK / finite BURST per channel,
// all stepping on a shared prescaler tick. Channels are reconfigured one at a time via cfg_wr.
module led_blink_ctrl #(
   parameter int CH_NUM   = 4,
   parameter int TICK_MAX = 49_999,
   parameter int PER_W    = 10,
   parameter int BST_W    = 8,
   localparam int CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              cfg_wr,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [1:0]        cfg_mode,
   input  logic [PER_W-1:0]  cfg_half,
   input  logic [BST_W-1:0]  cfg_burst,
   output logic [CH_NUM-1:0] led_out,
   output logic [CH_NUM-1:0] busy,
   output logic [CH_NUM-1:0] done
);

   localparam int PS_W = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_ON    = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_BURST = 2'b11
   } mode_e;

   logic [PS_W-1:0] presc_q, presc_d;
   logic            tick;

   assign tick = (presc_q == PS_W'(TICK_MAX));

   always_comb begin
      presc_d = presc_q + PS_W'(1);
      if (tick) begin
         presc_d = '0;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

   generate
      for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
         mode_e            mode_q,  mode_d;
         logic [PER_W-1:0] half_q,  half_d;
         logic [PER_W-1:0] phase_q, phase_d;
         logic [BST_W-1:0] rem_q,   rem_d;
         logic             led_q,   led_d;
         logic             done_q,  done_d;
         logic             wr_hit;
         logic [PER_W-1:0] half_eff;

         // Channel indices that do not exist can never match, so out-of-range writes are dropped.
         assign wr_hit   = cfg_wr && (cfg_ch == CH_W'(gi));
         assign half_eff = (half_q == '0) ? PER_W'(1) : half_q;

         always_comb begin
            mode_d  = mode_q;
            half_d  = half_q;
            phase_d = phase_q;
            rem_d   = rem_q;
            led_d   = led_q;
            done_d  = 1'b0;
            if (wr_hit) begin
               half_d  = cfg_half;
               rem_d   = cfg_burst;
               phase_d = '0;
               case (cfg_mode)
                  2'b01: begin
                     mode_d = MODE_ON;
                     led_d  = 1'b1;
                  end
                  2'b10: begin
                     mode_d = MODE_BLINK;
                     led_d  = 1'b1;
                  end
                  2'b11: begin
                     // A zero-length burst degenerates to OFF so busy never rises.
                     if (cfg_burst != '0) begin
                        mode_d = MODE_BURST;
                        led_d  = 1'b1;
                     end else begin
                        mode_d = MODE_OFF;
                        led_d  = 1'b0;
                     end
                  end
                  default: begin
                     mode_d = MODE_OFF;
                     led_d  = 1'b0;
                  end
               endcase
            end else if (tick && (mode_q == MODE_BLINK || mode_q == MODE_BURST)) begin
               if (phase_q == half_eff - PER_W'(1)) begin
                  phase_d = '0;
                  led_d   = ~led_q;
                  if (mode_q == MODE_BURST && led_q) begin
                     rem_d = rem_q - BST_W'(1);
                     if (rem_q == BST_W'(1)) begin
                        mode_d = MODE_OFF;
                        led_d  = 1'b0;
                        done_d = 1'b1;
                     end
                  end
               end else begin
                  phase_d = phase_q + PER_W'(1);
               end
            end
         end

         always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
               mode_q  <= MODE_OFF;
               half_q  <= '0;
               phase_q <= '0;
               rem_q   <= '0;
               led_q   <= 1'b0;
               done_q  <= 1'b0;
            end else begin
               mode_q  <= mode_d;
               half_q  <= half_d;
               phase_q <= phase_d;
               rem_q   <= rem_d;
               led_q   <= led_d;
               done_q  <= done_d;
            end
         end

         assign led_out[gi] = led_q;
         assign busy[gi]    = (mode_q == MODE_BURST);
         assign done[gi]    = done_q;
      end
   endgenerate

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Bench for led_blink_ctrl (3 channels, 4 clocks per tick): vector table, directed corner
// sequences and random writes, all checked against a tick-count based reference model.
module tb_led_blink_ctrl;

   localparam int CH = 3;
   localparam int TM = 3;
   localparam int T  = TM + 1;
   localparam int M_OFF = 0, M_ON = 1, M_BLINK = 2, M_BURST = 3;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic       cfg_wr = 1'b0;
   logic [1:0] cfg_ch = '0;
   logic [1:0] cfg_mode = '0;
   logic [9:0] cfg_half = '0;
   logic [7:0] cfg_burst = '0;
   logic [2:0] led_out, busy, done;

   led_blink_ctrl #(.CH_NUM(CH), .TICK_MAX(TM), .PER_W(10), .BST_W(8)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
      .cfg_mode(cfg_mode), .cfg_half(cfg_half), .cfg_burst(cfg_burst),
      .led_out(led_out), .busy(busy), .done(done)
   );

   always #5 sys_clk = ~sys_clk;

   int vec_cnt = 0;
   int err_cnt = 0;

   // Reference model: per channel, the last write (mode, effective half, burst, edge index).
   // Outputs follow from how many ticks have elapsed since that write.
   int edge_cnt;
   int m_mode[CH];
   int m_half[CH];
   int m_burst[CH];
   int m_w[CH];

   task automatic model_reset();
      edge_cnt = 0;
      for (int c = 0; c < CH; c++) begin
         m_mode[c] = M_OFF; m_half[c] = 1; m_burst[c] = 0; m_w[c] = 0;
      end
   endtask

   function automatic void model_exp(output logic [2:0] el, output logic [2:0] eb,
                                     output logic [2:0] ed);
      el = '0; eb = '0; ed = '0;
      for (int c = 0; c < CH; c++) begin
         int k, t, tp, endt;
         // ticks land on edges whose index is a multiple of T; the write edge itself never counts
         k = edge_cnt / T - m_w[c] / T;
         t = k / m_half[c];
         case (m_mode[c])
            M_ON:    el[c] = 1'b1;
            M_BLINK: el[c] = (t % 2 == 0);
            M_BURST: begin
               endt  = 2 * m_burst[c] - 1;
               el[c] = (t < endt) && (t % 2 == 0);
               eb[c] = (t < endt);
               if (edge_cnt > m_w[c]) begin
                  tp    = ((edge_cnt - 1) / T - m_w[c] / T) / m_half[c];
                  ed[c] = (t >= endt) && (tp < endt);
               end
            end
            default: ;
         endcase
      end
   endfunction

   task automatic step(input logic wr, input int ch, input int mode, input int half, input int burst);
      cfg_wr    = wr;
      cfg_ch    = 2'(ch);
      cfg_mode  = 2'(mode);
      cfg_half  = 10'(half);
      cfg_burst = 8'(burst);
      @(posedge sys_clk);
      if (!sys_rst) begin
         edge_cnt++;
         if (wr && ch < CH) begin
            m_w[ch]     = edge_cnt;
            m_half[ch]  = (half == 0) ? 1 : half;
            m_burst[ch] = burst;
            m_mode[ch]  = (mode == M_BURST && burst == 0) ? M_OFF : mode;
         end
      end
      #1;
      cfg_wr = 1'b0;
   endtask

   task automatic check(input string name, input logic [2:0] el, input logic [2:0] eb,
                        input logic [2:0] ed);
      vec_cnt++;
      if (led_out !== el || busy !== eb || done !== ed) begin
         err_cnt++;
         $display("FAIL %s edge=%0d: got led=%b busy=%b done=%b, expected led=%b busy=%b done=%b",
                  name, edge_cnt, led_out, busy, done, el, eb, ed);
      end
   endtask

   task automatic check_model(input string name);
      logic [2:0] el, eb, ed;
      model_exp(el, eb, ed);
      check(name, el, eb, ed);
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      vec_cnt++;
      if (got != exp) begin
         err_cnt++;
         $display("FAIL %s edge=%0d: got %0d, expected %0d", name, edge_cnt, got, exp);
      end
   endtask

   task automatic run(input int n, input string name);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 0, 0, 0, 0);
         check_model(name);
      end
   endtask

   typedef struct {
      logic       wr;
      int         ch;
      int         mode;
      int         half;
      int         burst;
      logic [2:0] led;
      logic [2:0] bsy;
      logic [2:0] dn;
   } vec_t;

   vec_t tbl[12];

   initial begin
      logic [2:0] prev_led;
      int last_tog, wr_edge, rises, dones;
      logic [3:0] hold;

      tbl[0]  = '{1'b0, 0, M_OFF,   0, 0, 3'b000, 3'b000, 3'b000};
      tbl[1]  = '{1'b1, 0, M_ON,    0, 0, 3'b001, 3'b000, 3'b000};
      tbl[2]  = '{1'b0, 0, M_OFF,   0, 0, 3'b001, 3'b000, 3'b000};
      tbl[3]  = '{1'b1, 0, M_OFF,   0, 0, 3'b000, 3'b000, 3'b000};
      tbl[4]  = '{1'b0, 0, M_OFF,   0, 0, 3'b000, 3'b000, 3'b000};
      tbl[5]  = '{1'b1, 2, M_ON,    0, 0, 3'b100, 3'b000, 3'b000};
      tbl[6]  = '{1'b1, 3, M_ON,    0, 0, 3'b100, 3'b000, 3'b000};
      tbl[7]  = '{1'b1, 1, M_BURST, 3, 0, 3'b100, 3'b000, 3'b000};
      tbl[8]  = '{1'b1, 1, M_BURST, 5, 2, 3'b110, 3'b010, 3'b000};
      tbl[9]  = '{1'b1, 2, M_OFF,   0, 0, 3'b010, 3'b010, 3'b000};
      tbl[10] = '{1'b1, 1, M_OFF,   0, 0, 3'b000, 3'b000, 3'b000};
      tbl[11] = '{1'b0, 0, M_OFF,   0, 0, 3'b000, 3'b000, 3'b000};

      // Reset held for 5 clocks
      model_reset();
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 0, 0, 0, 0);
         check("reset_hold", 3'b000, 3'b000, 3'b000);
      end
      sys_rst = 1'b0;

      foreach (tbl[i]) begin
         step(tbl[i].wr, tbl[i].ch, tbl[i].mode, tbl[i].half, tbl[i].burst);
         check($sformatf("table[%0d]", i), tbl[i].led, tbl[i].bsy, tbl[i].dn);
      end

      // BLINK ch1 half=2: first toggle within 5..8 clocks, then every 8 clocks
      step(1'b1, 1, M_BLINK, 2, 0);
      check_model("blink_write");
      wr_edge  = edge_cnt;
      last_tog = -1;
      prev_led = led_out;
      for (int i = 0; i < 170; i++) begin
         step(1'b0, 0, 0, 0, 0);
         check_model("blink_run");
         if (led_out[1] != prev_led[1]) begin
            if (last_tog < 0) begin
               check_int("blink_first_in_range",
                         int'((edge_cnt - wr_edge) >= 5 && (edge_cnt - wr_edge) <= 8), 1);
            end else begin
               check_int("blink_half_period", edge_cnt - last_tog, 8);
            end
            last_tog = edge_cnt;
         end
         prev_led = led_out;
      end
      step(1'b1, 1, M_OFF, 0, 0);
      check_model("blink_off");

      // BURST ch2 half=1 burst=3
      prev_led = led_out;
      step(1'b1, 2, M_BURST, 1, 3);
      check_model("burst_write");
      rises = 0; dones = 0;
      for (int i = 0; i < 45; i++) begin
         if (led_out[2] && !prev_led[2]) rises++;
         prev_led = led_out;
         step(1'b0, 0, 0, 0, 0);
         check_model("burst_run");
         if (done[2]) begin
            dones++;
            check_int("burst_done_on_fall", int'(prev_led[2] && !led_out[2] && !busy[2]), 1);
         end
      end
      check_int("burst_pulses", rises, 3);
      check_int("burst_done_count", dones, 1);

      // Write landing on the tick cycle ignores that tick
      for (int i = 0; i < 8 && (edge_cnt % T) != T - 1; i++) begin
         step(1'b0, 0, 0, 0, 0);
         check_model("align");
      end
      step(1'b1, 1, M_BLINK, 1, 0);
      check_model("collide_write");
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 0, 0, 0, 0);
         check_model("collide_run");
         hold[i] = led_out[1];
      end
      check_int("collide_hold", int'(hold), 4'b0111);
      prev_led = led_out;
      step(1'b1, 3, M_ON, 5, 5);
      check("bad_channel", prev_led, 3'b000, 3'b000);
      run(6, "bad_channel_after");

      // half=0 blinks every tick; burst=0 acts as OFF
      step(1'b1, 0, M_BLINK, 0, 0);
      check_model("half0_write");
      run(20, "half0_run");
      step(1'b1, 2, M_BURST, 2, 0);
      check("burst0_write", {1'b0, led_out[1:0]}, 3'b000, 3'b000);
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 0, 0, 0, 0);
         check_model("burst0_run");
         dones += int'(done[2]);
      end
      check_int("burst0_no_done", dones, 0);
      step(1'b1, 0, M_OFF, 0, 0);
      step(1'b1, 1, M_OFF, 0, 0);
      check_model("quiet");

      // Abort a burst by rewriting the channel
      step(1'b1, 2, M_BURST, 3, 4);
      run(10, "abort_pre");
      step(1'b1, 2, M_ON, 0, 0);
      check("abort_write", 3'b100, 3'b000, 3'b000);
      dones = 0;
      for (int i = 0; i < 60; i++) begin
         step(1'b0, 0, 0, 0, 0);
         check_model("abort_run");
         dones += int'(done[2]);
      end
      check_int("abort_no_done", dones, 0);

      // Asynchronous reset mid-burst
      step(1'b1, 2, M_BURST, 1, 5);
      run(6, "rst_pre");
      #2 sys_rst = 1'b1;
      #1 check("async_reset", 3'b000, 3'b000, 3'b000);
      model_reset();
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 0, 0, 0, 0);
         check("reset_mid", 3'b000, 3'b000, 3'b000);
      end
      sys_rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 0, 0, 0, 0);
         check_model("post_reset");
         dones += int'(done != 3'b000);
      end
      check_int("post_reset_no_done", dones, 0);

      // Random writes against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            step(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         end else begin
            step(1'b0, 0, 0, 0, 0);
         end
         check_model("random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
